mips_mmio_responder: RTL and testbench
======================================

Name: mips_mmio_responder

Overview:
- Memory-mapped I/O responder on the data-memory bus of the single-cycle MIPS core.
- Decodes memaddr/memwrite/memwritedata from the core and returns memreaddata in the same cycle.
- Holds a compare timer with an interrupt line and a transmit FIFO. The FIFO drains to an external sink over a valid/ready stream.
- The system read mux selects this block's data when hit=1 and data memory otherwise.

Parameters:
- BASE_ADDR, 32'hFFFF_0000, base of the 256-byte register window; bits [7:0] must be 0.
- FIFO_DEPTH, 4, TX FIFO entries; legal values 2, 4, 8.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- memwrite  input  1  core store strobe.
- memaddr  input  32  core byte address (ALU result).
- memwritedata  input  32  core store data.
- memreaddata  output  32  read data, combinational from memaddr and current state.
- hit  output  1  memaddr[31:8]==BASE_ADDR[31:8]; combinational.
- irq  output  1  timer interrupt request.
- out_valid  output  1  FIFO not empty.
- out_data  output  32  FIFO head word.
- out_ready  input  1  sink accepts the head word this cycle.

Behaviour:
- Select: sel = hit. Writes take effect at the clock edge only when sel & memwrite. Word offset is memaddr[7:2]; memaddr[1:0] is ignored.
- Register map (offset, name, access):
  - 0x00 COUNT, R/W.
  - 0x04 CMP, R/W.
  - 0x08 CTRL, R/W; bit0 EN, bit1 AUTORELOAD, bit2 IRQEN; other bits read 0.
  - 0x0C STATUS, R/W1C; bit0 MATCH (W1C), bit1 FULL (RO), bit2 EMPTY (RO), bit3 OVF (W1C), bits[7:4] FIFO count (RO).
  - 0x10 TXDATA, WO; reads 0.
  - All other offsets read 0; writes to them are ignored.
- Reads: memreaddata = selected register when sel, else 32'h0. Reads have no side effects.
- Reset (reset=0, immediate):
  - COUNT=0, CMP=32'hFFFF_FFFF, CTRL=0, MATCH=0, OVF=0.
  - FIFO pointers and count = 0, so out_valid=0.
  - irq=0, out_data=0.
- Timer, when EN=1, each edge:
  - COUNT==CMP: MATCH is set; next COUNT = AUTORELOAD ? 0 : COUNT+1.
  - Otherwise: COUNT = COUNT+1; 32'hFFFF_FFFF wraps to 0.
  - EN=0: COUNT holds and no match is detected.
- Write to COUNT: takes priority over increment and reload; COUNT = memwritedata that edge. A match is still evaluated on the pre-write value.
- Write to CMP: the new value is used from the next cycle.
- MATCH: hardware set and a W1C clear in the same cycle resolve to set.
- OVF: same set-wins rule as MATCH.
- irq = MATCH & IRQEN, registered state only; no combinational path from bus inputs.
- FIFO push: a write to TXDATA pushes memwritedata.
  - Accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped, OVF is set, and FIFO contents are unchanged.
- FIFO pop: when out_valid & out_ready.
  - out_data is the head entry, valid while out_valid=1. out_data is stable while out_valid=1 and out_ready=0.
  - Simultaneous push and pop on an empty FIFO: pop does nothing (out_valid=0); push is accepted and out_valid=1 next cycle.
  - Simultaneous push and pop on a non-empty FIFO: count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. FULL = count==FIFO_DEPTH. EMPTY = count==0.
- Latency:
  - Register read: 0 cycles.
  - Write to register-visible: 1 edge.
  - TXDATA write to out_valid: 1 edge.
- Reset mid-stream discards all FIFO contents and forces out_valid low immediately.

Test Plan:
- Reset and read map: release reset, read 0x00/0x04/0x08/0x0C at BASE_ADDR → 0, FFFF_FFFF, 0, 0x0000_0004 (EMPTY=1). memaddr=0x1000_0000 → hit=0, memreaddata=0.
- Compare and IRQ: write CMP=5, CTRL=0x7; after 6 edges STATUS.MATCH=1, irq=1, COUNT=0 (autoreload). Write STATUS=1 → MATCH=0, irq=0 next cycle.
- Count write vs increment: EN=1, write COUNT=0x100 → reads 0x100 next cycle, then 0x101. Let COUNT run to FFFF_FFFF with CMP≠it → wraps to 0.
- FIFO fill and overflow: out_ready=0; push 0xA0..0xA4. Result: FULL=1, count=4, OVF=1; out_data stays 0xA0.
- FIFO drain: from the full state, out_ready=1 → sink sees 0xA0..0xA3 in order, out_valid=0 after 4 pops.
- Concurrent push/pop: full FIFO, out_ready=1 with push 0xB0 → no OVF, count stays 4, 0xB0 drains last. Assert reset mid-drain → out_valid=0 immediately, STATUS count=0 after release.

Source files
------------

// File: rtl/mips_mmio_responder.sv
// MMIO responder on the MIPS data-memory bus: compare timer with interrupt and a
// transmit FIFO that drains to an external valid/ready sink.
module mips_mmio_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic [31:0] memreaddata,
  output logic        hit,
  output logic        irq,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready
);

  localparam int         PW      = $clog2(FIFO_DEPTH);
  localparam logic [3:0] DEPTH_C = 4'(FIFO_DEPTH);

  logic [31:0] count_r, cmp_r;
  logic [2:0]  ctrl_r;
  logic        match_r, ovf_r, irq_r;
  logic [3:0]  fifo_cnt_r;
  logic [PW-1:0] rd_ptr_r, wr_ptr_r;
  logic [31:0] fifo_mem_r [FIFO_DEPTH];

  logic [5:0]  offset_s;
  logic        wr_count_s, wr_cmp_s, wr_ctrl_s, wr_status_s, wr_tx_s;
  logic        pop_s, push_ok_s, ovf_set_s, match_set_s, full_s, empty_s;
  logic [31:0] count_nxt_s;
  logic [2:0]  ctrl_nxt_s;
  logic        match_nxt_s, ovf_nxt_s;
  logic [3:0]  fifo_cnt_nxt_s;
  logic        unused_addr_s;

  assign offset_s      = memaddr[7:2];
  assign unused_addr_s = ^memaddr[1:0];
  assign hit           = (memaddr[31:8] == BASE_ADDR[31:8]);
  assign wr_count_s    = hit & memwrite & (offset_s == 6'h00);
  assign wr_cmp_s      = hit & memwrite & (offset_s == 6'h01);
  assign wr_ctrl_s     = hit & memwrite & (offset_s == 6'h02);
  assign wr_status_s   = hit & memwrite & (offset_s == 6'h03);
  assign wr_tx_s       = hit & memwrite & (offset_s == 6'h04);

  assign empty_s   = (fifo_cnt_r == 4'd0);
  assign full_s    = (fifo_cnt_r == DEPTH_C);
  assign out_valid = ~empty_s;
  assign out_data  = out_valid ? fifo_mem_r[rd_ptr_r] : 32'h0;
  assign irq       = irq_r;

  assign pop_s     = out_valid & out_ready;
  // A pop in the same cycle frees the slot even when the FIFO is full.
  assign push_ok_s = wr_tx_s & ((fifo_cnt_r < DEPTH_C) | pop_s);
  assign ovf_set_s = wr_tx_s & ~push_ok_s;

  // Next-state for timer, status flags and FIFO occupancy.
  always_comb begin
    match_set_s = ctrl_r[0] & (count_r == cmp_r);
    if (wr_count_s) begin
      count_nxt_s = memwritedata;
    end else if (ctrl_r[0]) begin
      if (match_set_s && ctrl_r[1]) begin
        count_nxt_s = 32'h0;
      end else begin
        count_nxt_s = count_r + 32'd1;
      end
    end else begin
      count_nxt_s = count_r;
    end

    if (match_set_s) begin
      match_nxt_s = 1'b1;
    end else if (wr_status_s && memwritedata[0]) begin
      match_nxt_s = 1'b0;
    end else begin
      match_nxt_s = match_r;
    end

    if (ovf_set_s) begin
      ovf_nxt_s = 1'b1;
    end else if (wr_status_s && memwritedata[3]) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
    end

    if (wr_ctrl_s) begin
      ctrl_nxt_s = memwritedata[2:0];
    end else begin
      ctrl_nxt_s = ctrl_r;
    end

    case ({push_ok_s, pop_s})
      2'b10:   fifo_cnt_nxt_s = fifo_cnt_r + 4'd1;
      2'b01:   fifo_cnt_nxt_s = fifo_cnt_r - 4'd1;
      default: fifo_cnt_nxt_s = fifo_cnt_r;
    endcase
  end

  // Register state update; irq is registered from next-state so it tracks MATCH & IRQEN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r    <= 32'h0;
      cmp_r      <= 32'hFFFF_FFFF;
      ctrl_r     <= 3'b000;
      match_r    <= 1'b0;
      ovf_r      <= 1'b0;
      irq_r      <= 1'b0;
      fifo_cnt_r <= 4'd0;
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
    end else begin
      count_r    <= count_nxt_s;
      ctrl_r     <= ctrl_nxt_s;
      match_r    <= match_nxt_s;
      ovf_r      <= ovf_nxt_s;
      irq_r      <= match_nxt_s & ctrl_nxt_s[2];
      fifo_cnt_r <= fifo_cnt_nxt_s;
      if (wr_cmp_s) begin
        cmp_r <= memwritedata;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
    end
  end

  // FIFO storage; contents are don't-care while unoccupied.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      fifo_mem_r[wr_ptr_r] <= memwritedata;
    end
  end

  // Register read mux.
  always_comb begin
    if (hit) begin
      case (offset_s)
        6'h00:   memreaddata = count_r;
        6'h01:   memreaddata = cmp_r;
        6'h02:   memreaddata = {29'h0, ctrl_r};
        6'h03:   memreaddata = {24'h0, fifo_cnt_r, ovf_r, empty_s, full_s, match_r};
        default: memreaddata = 32'h0;
      endcase
    end else begin
      memreaddata = 32'h0;
    end
  end

endmodule

// File: tb/tb_mips_mmio_responder.sv
// Self-checking bench: directed register/FIFO scenarios plus randomized bus
// traffic compared against a queue-based behavioural model.
module tb_mips_mmio_responder;

  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int          DEPTH = 4;
  localparam logic [31:0] A_COUNT  = BASE + 32'h00;
  localparam logic [31:0] A_CMP    = BASE + 32'h04;
  localparam logic [31:0] A_CTRL   = BASE + 32'h08;
  localparam logic [31:0] A_STATUS = BASE + 32'h0C;
  localparam logic [31:0] A_TX     = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] memaddr = 32'h0;
  logic [31:0] memwritedata = 32'h0;
  logic [31:0] memreaddata;
  logic        hit, irq, out_valid, out_ready;
  logic [31:0] out_data;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_count, m_cmp;
  logic [2:0]  m_ctrl;
  logic        m_match, m_ovf;
  logic [31:0] m_q[$];

  mips_mmio_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .memaddr(memaddr),
    .memwritedata(memwritedata), .memreaddata(memreaddata), .hit(hit),
    .irq(irq), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 32'h0;
    m_cmp   = 32'hFFFF_FFFF;
    m_ctrl  = 3'b000;
    m_match = 1'b0;
    m_ovf   = 1'b0;
    m_q.delete();
  endtask

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    if (a[31:8] != BASE[31:8]) return 32'h0;
    case (a[7:2])
      6'd0: return m_count;
      6'd1: return m_cmp;
      6'd2: return {29'h0, m_ctrl};
      6'd3: return {24'h0, 4'(m_q.size()), m_ovf, (m_q.size() == 0), (m_q.size() == DEPTH), m_match};
      default: return 32'h0;
    endcase
  endfunction

  // One bus cycle: drive, compare visible outputs with the model, clock, advance the model.
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    logic sel, mhit, ovf_set, pop;
    int   n_before;
    logic [31:0] nc;
    memwrite = we; memaddr = a; memwritedata = d; out_ready = rdy;
    #2;
    check_eq("hit", 32'(hit), 32'(a[31:8] == BASE[31:8]));
    check_eq("rdata", memreaddata, mdl_read(a));
    check_eq("irq", 32'(irq), 32'(m_match & m_ctrl[2]));
    check_eq("valid", 32'(out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check_eq("odata", out_data, m_q[0]);
    @(posedge clk);
    sel = (a[31:8] == BASE[31:8]) && we;
    mhit = m_ctrl[0] && (m_count == m_cmp);
    if (sel && a[7:2] == 6'd0) nc = d;
    else if (m_ctrl[0]) nc = (mhit && m_ctrl[1]) ? 32'h0 : m_count + 32'd1;
    else nc = m_count;
    if (mhit) m_match = 1'b1;
    else if (sel && a[7:2] == 6'd3 && d[0]) m_match = 1'b0;
    n_before = m_q.size();
    pop = rdy && (n_before != 0);
    if (pop) void'(m_q.pop_front());
    ovf_set = 1'b0;
    if (sel && a[7:2] == 6'd4) begin
      if (n_before < DEPTH || pop) m_q.push_back(d);
      else ovf_set = 1'b1;
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (sel && a[7:2] == 6'd3 && d[3]) m_ovf = 1'b0;
    if (sel && a[7:2] == 6'd1) m_cmp = d;
    if (sel && a[7:2] == 6'd2) m_ctrl = d[2:0];
    m_count = nc;
    #1;
  endtask

  // Combinational read with no clock edge.
  task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
    memwrite = 1'b0; memaddr = a;
    #1;
    check_eq(tag, memreaddata, exp);
  endtask

  initial begin
    int r;
    logic [31:0] a, d;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(out_valid), 32'h0);
    check_eq("rst_irq", 32'(irq), 32'h0);
    reset = 1'b1;

    // Reset read map
    peek("rst_count", A_COUNT, 32'h0);
    peek("rst_cmp", A_CMP, 32'hFFFF_FFFF);
    peek("rst_ctrl", A_CTRL, 32'h0);
    peek("rst_status", A_STATUS, 32'h0000_0004);
    peek("miss_rdata", 32'h1000_0000, 32'h0);
    check_eq("miss_hit", 32'(hit), 32'h0);
    check_eq("rst_odata", out_data, 32'h0);

    // Compare, autoreload, IRQ
    step(1'b1, A_CMP, 32'd5, 1'b0);
    step(1'b1, A_CTRL, 32'h7, 1'b0);
    repeat (6) step(1'b0, A_STATUS, 32'h0, 1'b0);
    peek("match_status", A_STATUS, 32'h0000_0005);
    peek("match_count", A_COUNT, 32'h0);
    check_eq("match_irq", 32'(irq), 32'h1);
    step(1'b1, A_STATUS, 32'h1, 1'b0);
    peek("w1c_status", A_STATUS, 32'h0000_0004);
    check_eq("w1c_irq", 32'(irq), 32'h0);

    // Count write priority and wrap
    step(1'b1, A_COUNT, 32'h100, 1'b0);
    peek("cnt_wr", A_COUNT, 32'h100);
    step(1'b0, A_COUNT, 32'h0, 1'b0);
    peek("cnt_inc", A_COUNT, 32'h101);
    step(1'b1, A_COUNT, 32'hFFFF_FFFE, 1'b0);
    step(1'b0, A_COUNT, 32'h0, 1'b0);
    peek("cnt_max", A_COUNT, 32'hFFFF_FFFF);
    step(1'b0, A_COUNT, 32'h0, 1'b0);
    peek("cnt_wrap", A_COUNT, 32'h0);
    step(1'b1, A_CTRL, 32'h0, 1'b0);

    // FIFO fill with overflow, then drain
    for (int i = 0; i < 5; i++) step(1'b1, A_TX, 32'hA0 + 32'(i), 1'b0);
    peek("full_status", A_STATUS, 32'h0000_004A);
    check_eq("full_head", out_data, 32'hA0);
    for (int i = 0; i < 4; i++) begin
      check_eq("drain", out_data, 32'hA0 + 32'(i));
      step(1'b0, A_COUNT, 32'h0, 1'b1);
    end
    check_eq("drained_valid", 32'(out_valid), 32'h0);
    step(1'b1, A_STATUS, 32'h8, 1'b0);
    peek("ovf_clr", A_STATUS, 32'h0000_0004);

    // Concurrent push/pop on a full FIFO
    for (int i = 0; i < 4; i++) step(1'b1, A_TX, 32'hA0 + 32'(i), 1'b0);
    step(1'b1, A_TX, 32'hB0, 1'b1);
    peek("pushpop_status", A_STATUS, 32'h0000_0042);
    for (int i = 0; i < 4; i++) begin
      check_eq("drain2", out_data, (i == 3) ? 32'hB0 : 32'hA1 + 32'(i));
      step(1'b0, A_COUNT, 32'h0, 1'b1);
    end

    // Reset mid-drain
    step(1'b1, A_TX, 32'hC0, 1'b0);
    step(1'b1, A_TX, 32'hC1, 1'b0);
    step(1'b0, A_COUNT, 32'h0, 1'b1);
    reset = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    peek("midrst_status", A_STATUS, 32'h0000_0004);
    check_eq("midrst_odata", out_data, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 8) a = BASE + 32'(r * 4) + 32'($urandom_range(0, 3));
      else if (r == 8) a = BASE + 32'($urandom_range(0, 255));
      else a = $urandom;
      d = (r < 2) ? 32'($urandom_range(0, 30)) : $urandom;
      step(1'($urandom_range(0, 1)), a, d, 1'($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
